matrix_multiplier_seq: RTL

Parametrised N x N integer matrix multiplier computing C = A x B with a single time-shared multiply-accumulate unit (one MAC per cycle). It is the generalised successor of the fixed 2x2 multiplier top level: element width, dimension and accumulator width are parameters. A start/busy/done handshake controls operation, and results stream out one element at a time over a valid/ready interface with a row-major index. It sits between the operand source and the result store/display logic.

---
 rtl/matmul_pkg.sv | 25 ++
 rtl/matrix_multiplier_seq_if.sv | 31 +++
 rtl/matmul_mac_unit.sv | 57 +++++
 rtl/matrix_multiplier_seq.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential N x N matrix multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Wide enough that N products of full-scale elements cannot overflow.
  function automatic int acc_w_f(input int n, input int elem_w);
    return 2 * elem_w + $clog2(n);
  endfunction

  function automatic int idx_w_f(input int n);
    return $clog2(n * n);
  endfunction

  // LSB of element (r,c) in a row-major packed matrix.
  function automatic int elem_lsb(input int r, input int c, input int n, input int elem_w);
    return (r * n + c) * elem_w;
  endfunction

endpackage

// File: rtl/matrix_multiplier_seq_if.sv
// Operand/handshake/result bundle for matrix_multiplier_seq.
interface matrix_multiplier_seq_if
  import matmul_pkg::*;
#(
  parameter int N      = 2,
  parameter int ELEM_W = 4,
  parameter int ACC_W  = acc_w_f(N, ELEM_W),
  parameter int IDX_W  = idx_w_f(N)
) ();

  logic                    start;
  logic [N*N*ELEM_W-1:0]   matrix_a;
  logic [N*N*ELEM_W-1:0]   matrix_b;
  logic                    busy;
  logic                    result_valid;
  logic                    result_ready;
  logic [ACC_W-1:0]        result_data;
  logic [IDX_W-1:0]        result_index;
  logic                    done;

  modport master (
    output start, matrix_a, matrix_b, result_ready,
    input  busy, result_valid, result_data, result_index, done
  );

  modport slave (
    input  start, matrix_a, matrix_b, result_ready,
    output busy, result_valid, result_data, result_index, done
  );

endinterface

// File: rtl/matmul_mac_unit.sv
// Multiply-accumulate unit; MATMUL_SIGNED_EN selects two's-complement operands.
module matmul_mac_unit #(
  parameter int ELEM_W = 4,
  parameter int ACC_W  = 9
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ACC_W-1:0]  sum
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] prod_ext;

`ifdef MATMUL_SIGNED_EN
  logic signed [2*ELEM_W-1:0] a_x;
  logic signed [2*ELEM_W-1:0] b_x;
  logic signed [2*ELEM_W-1:0] prod;

  // Sign-extend before multiplying so the low 2*ELEM_W bits are the exact signed product.
  always_comb begin
    a_x      = {{ELEM_W{a[ELEM_W-1]}}, a};
    b_x      = {{ELEM_W{b[ELEM_W-1]}}, b};
    prod     = a_x * b_x;
    prod_ext = {{(ACC_W-2*ELEM_W){prod[2*ELEM_W-1]}}, prod};
  end
`else
  logic [2*ELEM_W-1:0] a_x;
  logic [2*ELEM_W-1:0] b_x;
  logic [2*ELEM_W-1:0] prod;

  always_comb begin
    a_x      = {{ELEM_W{1'b0}}, a};
    b_x      = {{ELEM_W{1'b0}}, b};
    prod     = a_x * b_x;
    prod_ext = {{(ACC_W-2*ELEM_W){1'b0}}, prod};
  end
`endif

  always_comb begin
    sum   = acc_q + prod_ext;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

endmodule

// File: rtl/matrix_multiplier_seq.sv
// N x N matrix multiplier with one shared MAC; results stream out row-major.
// Optional build macro: MATMUL_SIGNED_EN (two's-complement elements).
module matrix_multiplier_seq
  import matmul_pkg::*;
#(
  parameter int N      = 2,
  parameter int ELEM_W = 4,
  parameter int ACC_W  = acc_w_f(N, ELEM_W),
  parameter int IDX_W  = idx_w_f(N)
) (
  input  logic                    clock,
  input  logic                    reset,
  matrix_multiplier_seq_if.slave  bus
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MAT_W = N * N * ELEM_W;

  state_e              state_q, state_d;
  logic [MAT_W-1:0]    a_q, a_d;
  logic [MAT_W-1:0]    b_q, b_d;
  logic [CNT_W-1:0]    i_q, i_d;
  logic [CNT_W-1:0]    j_q, j_d;
  logic [CNT_W-1:0]    k_q, k_d;
  logic                res_valid_q, res_valid_d;
  logic [ACC_W-1:0]    res_data_q, res_data_d;
  logic [IDX_W-1:0]    res_index_q, res_index_d;
  logic                mac_clr;
  logic                mac_en;
  logic [ELEM_W-1:0]   a_elem;
  logic [ELEM_W-1:0]   b_elem;
  logic [ACC_W-1:0]    mac_sum;

  matmul_mac_unit #(
    .ELEM_W (ELEM_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clock),
    .clr (reset | mac_clr),
    .en  (mac_en),
    .a   (a_elem),
    .b   (b_elem),
    .sum (mac_sum)
  );

  always_comb begin
    a_elem = a_q[elem_lsb(int'(i_q), int'(k_q), N, ELEM_W) +: ELEM_W];
    b_elem = b_q[elem_lsb(int'(k_q), int'(j_q), N, ELEM_W) +: ELEM_W];
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_index_d = res_index_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.matrix_a;
          b_d     = bus.matrix_b;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == CNT_W'(N - 1)) begin
          res_data_d  = mac_sum;
          res_index_d = IDX_W'(int'(i_q) * N + int'(j_q));
          res_valid_d = 1'b1;
          mac_clr     = 1'b1;
          k_d         = '0;
          state_d     = EMIT;
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      EMIT: begin
        if (res_valid_q && bus.result_ready) begin
          res_valid_d = 1'b0;
          if (i_q == CNT_W'(N - 1) && j_q == CNT_W'(N - 1)) begin
            state_d = DONE;
          end else begin
            if (j_q == CNT_W'(N - 1)) begin
              j_d = '0;
              i_d = i_q + CNT_W'(1);
            end else begin
              j_d = j_q + CNT_W'(1);
            end
            state_d = MAC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_index_q <= res_index_d;
    end
  end

  // Operand snapshot only loads on an accepted start, so it needs no reset.
  always_ff @(posedge clock) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.result_valid = res_valid_q;
  assign bus.result_data  = res_data_q;
  assign bus.result_index = res_index_q;

endmodule
